// File: rtl/merge_seq_pkg.sv
// rtl/merge_seq_pkg.sv - state encoding and shared constants for the merge pass sequencer
package merge_seq_pkg;

  localparam int DEFAULT_N_LOG2 = 3;
  localparam int CNT_W          = 16;

  typedef enum logic [4:0] {
    INI   = 5'b00001,
    ISSUE = 5'b00010,
    WAIT  = 5'b00100,
    NEXT  = 5'b01000,
    DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/merge_pass_sequencer_if.sv
// rtl/merge_pass_sequencer_if.sv - host and merge-core handshake bundle for the merge pass sequencer
interface merge_pass_sequencer_if
  import merge_seq_pkg::*;
#(
  parameter int N_LOG2 = DEFAULT_N_LOG2
);

  logic              start;
  logic              ack;
  logic              done;
  logic              result_bank;
  logic              mrg_start;
  logic              mrg_done;
  logic              mrg_ack;
  logic [N_LOG2-1:0] mrg_p_base;
  logic [N_LOG2-1:0] mrg_q_base;
  logic [N_LOG2-1:0] mrg_r_base;
  logic [N_LOG2-1:0] mrg_len;
  logic              mrg_src_bank;
  logic [CNT_W-1:0]  cycles_taken;

  modport master (
    input  start, ack, mrg_done,
    output done, result_bank, mrg_start, mrg_ack,
           mrg_p_base, mrg_q_base, mrg_r_base, mrg_len, mrg_src_bank, cycles_taken
  );

  modport slave (
    output start, ack, mrg_done,
    input  done, result_bank, mrg_start, mrg_ack,
           mrg_p_base, mrg_q_base, mrg_r_base, mrg_len, mrg_src_bank, cycles_taken
  );

endinterface

// File: rtl/merge_job_addr_gen.sv
// rtl/merge_job_addr_gen.sv - maps (pass, job) to the run bases, run length and source bank of a merge job
module merge_job_addr_gen
  import merge_seq_pkg::*;
#(
  parameter int N_LOG2 = DEFAULT_N_LOG2
) (
  input  logic [N_LOG2-1:0] pass,
  input  logic [N_LOG2-1:0] job,
  output logic [N_LOG2-1:0] p_base,
  output logic [N_LOG2-1:0] q_base,
  output logic [N_LOG2-1:0] r_base,
  output logic [N_LOG2-1:0] len,
  output logic              src_bank
);

  localparam logic [N_LOG2-1:0] ONE = N_LOG2'(1);

  always_comb begin
    len      = ONE << pass;
    // each job consumes two runs of length 2^pass
    p_base   = (job << pass) << 1;
    q_base   = p_base + len;
    r_base   = p_base;
    src_bank = pass[0];
  end

endmodule

// File: rtl/merge_pass_sequencer.sv
// rtl/merge_pass_sequencer.sv - sequences bottom-up merge sort passes through a shared merge core
// MERGE_SEQ_CYCLE_CNT_EN builds the saturating sort-cycle counter behind cycles_taken.
module merge_pass_sequencer
  import merge_seq_pkg::*;
#(
  parameter int N_LOG2 = DEFAULT_N_LOG2
) (
  input logic                   clk,
  input logic                   reset,
  merge_pass_sequencer_if.master bus
);

  localparam logic [N_LOG2-1:0] ONE         = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] PASS_LAST   = N_LOG2'(N_LOG2 - 1);
  localparam logic              RESULT_BANK = 1'(N_LOG2 % 2);

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] pass_q, pass_d, job_q, job_d;
  logic [N_LOG2-1:0] gen_p, gen_q, gen_r, gen_len;
  logic              gen_src;
  logic [N_LOG2-1:0] p_base_q, p_base_d, q_base_q, q_base_d, r_base_q, r_base_d, len_q, len_d;
  logic              src_bank_q, src_bank_d;
  logic              done_q, done_d, result_bank_q, result_bank_d;
  logic              mrg_start_q, mrg_start_d, mrg_ack_q, mrg_ack_d;
  logic [N_LOG2-1:0] span_end;
  logic              last_job, job_active;

  merge_job_addr_gen #(.N_LOG2(N_LOG2)) u_addr (
    .pass     (pass_d),
    .job      (job_d),
    .p_base   (gen_p),
    .q_base   (gen_q),
    .r_base   (gen_r),
    .len      (gen_len),
    .src_bank (gen_src)
  );

  // the last job of a pass ends exactly at the top of the buffer, wrapping to 0
  assign span_end = p_base_q + (len_q << 1);
  assign last_job = (span_end == '0);

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    job_d   = job_q;
    case (state_q)
      INI: if (bus.start) begin
        pass_d  = '0;
        job_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.mrg_done) state_d = NEXT;
      NEXT: begin
        if (!last_job) begin
          job_d   = job_q + ONE;
          state_d = ISSUE;
        end else if (pass_q != PASS_LAST) begin
          pass_d  = pass_q + ONE;
          job_d   = '0;
          state_d = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    if (bus.ack) state_d = INI;
      default: state_d = INI;
    endcase

    job_active    = state_d inside {ISSUE, WAIT, NEXT};
    p_base_d      = job_active ? gen_p   : '0;
    q_base_d      = job_active ? gen_q   : '0;
    r_base_d      = job_active ? gen_r   : '0;
    len_d         = job_active ? gen_len : '0;
    src_bank_d    = job_active & gen_src;
    done_d        = (state_d == DONE);
    result_bank_d = (state_d == DONE) & RESULT_BANK;
    mrg_start_d   = (state_d == ISSUE);
    mrg_ack_d     = (state_d == NEXT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INI;
      pass_q        <= '0;
      job_q         <= '0;
      p_base_q      <= '0;
      q_base_q      <= '0;
      r_base_q      <= '0;
      len_q         <= '0;
      src_bank_q    <= 1'b0;
      done_q        <= 1'b0;
      result_bank_q <= 1'b0;
      mrg_start_q   <= 1'b0;
      mrg_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      job_q         <= job_d;
      p_base_q      <= p_base_d;
      q_base_q      <= q_base_d;
      r_base_q      <= r_base_d;
      len_q         <= len_d;
      src_bank_q    <= src_bank_d;
      done_q        <= done_d;
      result_bank_q <= result_bank_d;
      mrg_start_q   <= mrg_start_d;
      mrg_ack_q     <= mrg_ack_d;
    end
  end

  assign bus.done         = done_q;
  assign bus.result_bank  = result_bank_q;
  assign bus.mrg_start    = mrg_start_q;
  assign bus.mrg_ack      = mrg_ack_q;
  assign bus.mrg_p_base   = p_base_q;
  assign bus.mrg_q_base   = q_base_q;
  assign bus.mrg_r_base   = r_base_q;
  assign bus.mrg_len      = len_q;
  assign bus.mrg_src_bank = src_bank_q;

`ifdef MERGE_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == INI && bus.start) begin
      cnt_d = '0;
    end else if ((state_q inside {ISSUE, WAIT, NEXT}) && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cycles_taken = cnt_q;
`else
  assign bus.cycles_taken = '0;
`endif

endmodule

// File: tb/tb_merge_pass_sequencer.sv
// tb/tb_merge_pass_sequencer.sv - self-checking bench for merge_pass_sequencer with stub merge cores
module tb_merge_pass_sequencer;
  import merge_seq_pkg::*;

  typedef struct packed {
    logic [5:0] p;
    logic [5:0] q;
    logic [5:0] r;
    logic [5:0] len;
    logic       src;
  } job_t;

  typedef struct {
    int   idx;
    job_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  merge_pass_sequencer_if #(.N_LOG2(3)) b3 ();
  merge_pass_sequencer_if #(.N_LOG2(1)) b1 ();

  merge_pass_sequencer #(.N_LOG2(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.master));
  merge_pass_sequencer #(.N_LOG2(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.master));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic job_t mk(input int p, input int q, input int r, input int len, input int src);
    job_t j;
    j.p = 6'(p); j.q = 6'(q); j.r = 6'(r); j.len = 6'(len); j.src = 1'(src);
    return j;
  endfunction

  // Reference: runs of length 2^p paired left to right across the buffer
  job_t exp_q[$];
  task automatic build_model(input int nl);
    int n;
    n = 1 << nl;
    exp_q.delete();
    for (int p = 0; p < nl; p++) begin
      for (int base = 0; base < n; base += (2 << p))
        exp_q.push_back(mk(base, base + (1 << p), base, 1 << p, p % 2));
    end
  endtask

  // Stub cores: raise mrg_done on the W-th WAIT cycle, drop it on mrg_ack
  bit rand_wait = 0;
  int w3, wt3, wc3, cost3 = 0, wc1;
  bit busy3, busy1;

  always @(posedge clk) begin
    if (reset) begin
      busy3 <= 0; wc3 <= 0; b3.mrg_done <= 1'b0;
    end else if (b3.mrg_ack) begin
      busy3 <= 0; b3.mrg_done <= 1'b0;
    end else if (b3.mrg_start) begin
      w3 = rand_wait ? int'($urandom_range(1, 6)) : 3;
      wt3 <= w3; wc3 <= 1; busy3 <= 1;
      b3.mrg_done <= (w3 == 1);
      cost3 <= cost3 + 2 + w3;
    end else if (busy3 && !b3.mrg_done) begin
      wc3 <= wc3 + 1;
      if (wc3 + 1 == wt3) b3.mrg_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      busy1 <= 0; wc1 <= 0; b1.mrg_done <= 1'b0;
    end else if (b1.mrg_ack) begin
      busy1 <= 0; b1.mrg_done <= 1'b0;
    end else if (b1.mrg_start) begin
      wc1 <= 1; busy1 <= 1; b1.mrg_done <= 1'b0;
    end else if (busy1 && !b1.mrg_done) begin
      wc1 <= wc1 + 1;
      if (wc1 + 1 == 3) b1.mrg_done <= 1'b1;
    end
  end

  // Monitors record every issued job and pulse-shape violations
  job_t obs3[$];
  job_t obs1[$];
  int n_start3 = 0, n_ack3 = 0, n_wide3 = 0, n_sdone3 = 0;
  bit prev_s3 = 0, prev_a3 = 0;

  always @(negedge clk) begin
    if (b3.mrg_start) begin
      n_start3++;
      if (prev_s3) n_wide3++;
      if (b3.mrg_done) n_sdone3++;
      obs3.push_back(mk(int'(b3.mrg_p_base), int'(b3.mrg_q_base), int'(b3.mrg_r_base),
                        int'(b3.mrg_len), int'(b3.mrg_src_bank)));
    end
    if (b3.mrg_ack) begin
      n_ack3++;
      if (prev_a3) n_wide3++;
    end
    prev_s3 = b3.mrg_start;
    prev_a3 = b3.mrg_ack;
    if (b1.mrg_start)
      obs1.push_back(mk(int'(b1.mrg_p_base), int'(b1.mrg_q_base), int'(b1.mrg_r_base),
                        int'(b1.mrg_len), int'(b1.mrg_src_bank)));
  end

  function automatic int outs3();
    return int'({b3.done, b3.mrg_start, b3.mrg_ack, b3.mrg_p_base, b3.mrg_q_base,
                 b3.mrg_r_base, b3.mrg_len, b3.mrg_src_bank});
  endfunction

  function automatic int outs1();
    return int'({b1.done, b1.mrg_start, b1.mrg_ack, b1.mrg_p_base, b1.mrg_q_base,
                 b1.mrg_r_base, b1.mrg_len, b1.mrg_src_bank});
  endfunction

  task automatic run3(input bit noise, output int base, output int cost0);
    bit ok;
    base  = obs3.size();
    cost0 = cost3;
    b3.start = 1'b1;
    @(negedge clk);
    chk("start_latency", int'(b3.mrg_start), 1);
    b3.start = noise ? 1'($urandom % 2) : 1'b0;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (b3.done) begin ok = 1; break; end
      if (noise) begin
        b3.start = 1'($urandom % 2);
        b3.ack   = 1'($urandom % 2);
      end
    end
    b3.start = 1'b0;
    b3.ack   = 1'b0;
    chk("done_within_budget", int'(ok), 1);
  endtask

  task automatic verify3(input int base, input int exp_cyc);
    chk("job_count", obs3.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < obs3.size())
        chk($sformatf("job%0d_vs_model", i), int'(obs3[base + i]), int'(exp_q[i]));
    chk("done_high", int'(b3.done), 1);
    chk("result_bank", int'(b3.result_bank), 1);
`ifdef MERGE_SEQ_CYCLE_CNT_EN
    chk("cycles_taken", int'(b3.cycles_taken), exp_cyc);
`else
    chk("cycles_taken", int'(b3.cycles_taken), 0);
    if (exp_cyc < 0) $display("note: negative cycle expectation %0d", exp_cyc);
`endif
  endtask

  task automatic ack3(input int exp_cyc);
    repeat (2) @(negedge clk);
    chk("done_holds", int'(b3.done), 1);
    b3.ack = 1'b1;
    @(negedge clk);
    b3.ack = 1'b0;
    chk("done_falls", int'(b3.done), 0);
    chk("job_outs_zero_in_ini", outs3(), 0);
`ifdef MERGE_SEQ_CYCLE_CNT_EN
    chk("cycles_hold_in_ini", int'(b3.cycles_taken), exp_cyc);
`else
    chk("cycles_hold_in_ini", int'(b3.cycles_taken), 0);
    if (exp_cyc < 0) $display("note: negative cycle expectation %0d", exp_cyc);
`endif
  endtask

  vec_t spec_tab[7];
  int   base, cost0, s0, a0, seen, base1;
  bit   ok1;

  initial begin
    spec_tab[0] = '{idx: 0, exp: mk(0, 1, 0, 1, 0)};
    spec_tab[1] = '{idx: 1, exp: mk(2, 3, 2, 1, 0)};
    spec_tab[2] = '{idx: 2, exp: mk(4, 5, 4, 1, 0)};
    spec_tab[3] = '{idx: 3, exp: mk(6, 7, 6, 1, 0)};
    spec_tab[4] = '{idx: 4, exp: mk(0, 2, 0, 2, 1)};
    spec_tab[5] = '{idx: 5, exp: mk(4, 6, 4, 2, 1)};
    spec_tab[6] = '{idx: 6, exp: mk(0, 4, 0, 4, 0)};

    reset = 1'b1;
    b3.start = 1'b0; b3.ack = 1'b0;
    b1.start = 1'b0; b1.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs3", outs3(), 0);
    chk("reset_result_bank3", int'(b3.result_bank), 0);
    chk("reset_cycles3", int'(b3.cycles_taken), 0);
    chk("reset_outs1", outs1(), 0);
    chk("reset_result_bank1", int'(b1.result_bank), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", int'(b3.mrg_start), 0);

    // Full sort, fixed core latency
    build_model(3);
    s0 = n_start3; a0 = n_ack3;
    run3(1'b0, base, cost0);
    for (int i = 0; i < 7; i++)
      if (base + spec_tab[i].idx < obs3.size())
        chk($sformatf("spec_job%0d", i), int'(obs3[base + spec_tab[i].idx]), int'(spec_tab[i].exp));
    chk("mrg_start_pulses", n_start3 - s0, 7);
    chk("mrg_ack_pulses", n_ack3 - a0, 7);
    chk("stub_cost_model", cost3 - cost0, 35);
    verify3(base, 35);
    ack3(35);

    // Reset while waiting on the third job
    b3.start = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && seen < 3; c++) begin
      @(negedge clk);
      b3.start = 1'b0;
      if (b3.mrg_start) seen++;
    end
    chk("reached_job3", seen, 3);
    @(negedge clk);
    chk("job3_p_base_in_wait", int'(b3.mrg_p_base), 4);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_outs", outs3(), 0);
    chk("reset_mid_result_bank", int'(b3.result_bank), 0);
    chk("reset_mid_cycles", int'(b3.cycles_taken), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mid_idle", outs3(), 0);
    run3(1'b0, base, cost0);
    if (base < obs3.size())
      chk("restart_first_job", int'(obs3[base]), int'(spec_tab[0].exp));
    verify3(base, 35);
    ack3(35);

    // Random core latencies with Start/Ack noise during the run
    rand_wait = 1;
    for (int r = 0; r < 3; r++) begin
      run3(1'b1, base, cost0);
      verify3(base, cost3 - cost0);
      ack3(cost3 - cost0);
    end
    rand_wait = 0;

    // Start and Ack together in DONE
    run3(1'b0, base, cost0);
    verify3(base, 35);
    b3.start = 1'b1; b3.ack = 1'b1;
    @(negedge clk);
    b3.ack = 1'b0;
    chk("sim_done_falls", int'(b3.done), 0);
    chk("sim_ini_no_issue", int'(b3.mrg_start), 0);
    @(negedge clk);
    b3.start = 1'b0;
    chk("sim_issue_after_ini", int'(b3.mrg_start), 1);
    ok1 = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (b3.done) begin ok1 = 1; break; end
    end
    chk("sim_drain_done", int'(ok1), 1);
    ack3(35);

    // Smallest buffer: one job
    build_model(1);
    base1 = obs1.size();
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    chk("n1_start_latency", int'(b1.mrg_start), 1);
    ok1 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (b1.done) begin ok1 = 1; break; end
    end
    chk("n1_done_within_budget", int'(ok1), 1);
    chk("n1_job_count", obs1.size() - base1, exp_q.size());
    if (base1 < obs1.size()) begin
      chk("n1_job_vs_model", int'(obs1[base1]), int'(exp_q[0]));
      chk("n1_job_vs_spec", int'(obs1[base1]), int'(spec_tab[0].exp));
    end
    chk("n1_result_bank", int'(b1.result_bank), 1);
`ifdef MERGE_SEQ_CYCLE_CNT_EN
    chk("n1_cycles_taken", int'(b1.cycles_taken), 5);
`else
    chk("n1_cycles_taken", int'(b1.cycles_taken), 0);
`endif
    b1.ack = 1'b1;
    @(negedge clk);
    b1.ack = 1'b0;
    chk("n1_done_falls", int'(b1.done), 0);

    chk("single_cycle_pulses", n_wide3, 0);
    chk("no_start_while_done", n_sdone3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
